// File: rtl/seq_divider32_pkg.sv
// Shared definitions for the sequential 32-bit divider.
//   state_t      : FSM state encoding (IDLE, CALC, FIX, DONE)
//   DIV_WIDTH    : operand/result width
//   CNT_W        : width of the step counter (must hold the value DIV_WIDTH)
//   twos_neg()   : two's-complement negation modulo 2^DIV_WIDTH
package seq_divider32_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [DIV_WIDTH-1:0] twos_neg(input logic [DIV_WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

endpackage

// File: rtl/bit32_ripple_carry_adder.sv
// 32-bit ripple-carry adder: Sum_out = A_in + B_in + C_in, carry out on C_out.
// The divider uses it as a subtractor by feeding B_in = ~divisor and C_in = 1,
// so C_out = 1 means "no borrow".
//   A_in, B_in : 32-bit addends
//   C_in       : carry in
//   Sum_out    : 32-bit sum
//   C_out      : carry out of bit 31
module bit32_ripple_carry_adder (
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  input  logic        C_in,
  output logic [31:0] Sum_out,
  output logic        C_out
);

  logic [32:0] carry;

  assign carry[0] = C_in;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign Sum_out[i]  = A_in[i] ^ B_in[i] ^ carry[i];
    assign carry[i+1]  = (A_in[i] & B_in[i]) | (carry[i] & (A_in[i] ^ B_in[i]));
  end

  assign C_out = carry[32];

endmodule

// File: rtl/seq_divider32.sv
// Iterative radix-2 restoring divider for MIPS32 DIV/DIVU.
// One quotient bit per clock; fixed latency of WIDTH+2 cycles from the start
// cycle to the done pulse (CALC x WIDTH, FIX, DONE).
//   clk_in          : clock, rising edge
//   rst_in          : synchronous active-high reset
//   start_in        : request, accepted only in IDLE
//   signed_in       : 1 = DIV (two's complement), 0 = DIVU
//   dividend_in     : dividend, sampled with start_in
//   divisor_in      : divisor, sampled with start_in
//   quotient_out    : quotient (LO), updated at end of FIX
//   remainder_out   : remainder (HI), updated at end of FIX
//   busy_out        : high from the cycle after start through the done cycle
//   done_out        : one-cycle pulse, results valid from this cycle
//   div_by_zero_out : divisor was zero; held with the results
module seq_divider32
  import seq_divider32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             div_by_zero_out
);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;      // partial remainder (always < divisor between steps)
  logic [WIDTH-1:0]   quo_q;      // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
  logic [WIDTH-1:0]   dvd_raw_q;  // untouched dividend, returned on divide-by-zero
  logic               qneg_q;     // negate quotient in FIX
  logic               rneg_q;     // negate remainder in FIX
  logic               dbz_q;

  logic [WIDTH-1:0]   quotient_q;
  logic [WIDTH-1:0]   remainder_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_out_q;

  // Step datapath: WIDTH+1-bit shifted remainder, trial subtract on the adder.
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               carry;
  logic               take;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;

  assign shifted = {rem_q, quo_q[WIDTH-1]};

  bit32_ripple_carry_adder u_sub (
    .A_in    (shifted[WIDTH-1:0]),
    .B_in    (~dvs_q),
    .C_in    (1'b1),
    .Sum_out (diff),
    .C_out   (carry)
  );

  // A set bit shifted out of the remainder means the 33-bit value already
  // exceeds any 32-bit divisor, even though the 32-bit adder shows a borrow.
  assign take  = carry | shifted[WIDTH];
  assign rem_d = take ? diff : shifted[WIDTH-1:0];
  assign quo_d = {quo_q[WIDTH-2:0], take};

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let later lines see new state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_raw_q   <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_out_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            dvs_q     <= (signed_in && divisor_in[WIDTH-1])  ? twos_neg(divisor_in)  : divisor_in;
            quo_q     <= (signed_in && dividend_in[WIDTH-1]) ? twos_neg(dividend_in) : dividend_in;
            rem_q     <= '0;
            dvd_raw_q <= dividend_in;
            qneg_q    <= signed_in & (dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1]);
            rneg_q    <= signed_in & dividend_in[WIDTH-1];
            dbz_q     <= (divisor_in == '0);
            cnt_q     <= CNT_W'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= ST_CALC;
          end
        end
        ST_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          if (dbz_q) begin
            quotient_q  <= '1;
            remainder_q <= dvd_raw_q;
          end else begin
            quotient_q  <= qneg_q ? twos_neg(quo_q) : quo_q;
            remainder_q <= rneg_q ? twos_neg(rem_q) : rem_q;
          end
          dbz_out_q <= dbz_q;
          done_q    <= 1'b1;
          state_q   <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign quotient_out    = quotient_q;
  assign remainder_out   = remainder_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign div_by_zero_out = dbz_out_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: directed corner cases, handshake and
// reset scenarios, then random operands against an arithmetic reference model.
module tb_seq_divider32;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic        signed_in;
  logic [31:0] dividend_in;
  logic [31:0] divisor_in;
  logic [31:0] quotient_out;
  logic [31:0] remainder_out;
  logic        busy_out;
  logic        done_out;
  logic        div_by_zero_out;

  int n_cmp = 0;
  int n_err = 0;

  // Last results the bench expects to be held on the outputs.
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;
  logic        last_z = 1'b0;

  seq_divider32 dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .signed_in       (signed_in),
    .dividend_in     (dividend_in),
    .divisor_in      (divisor_in),
    .quotient_out    (quotient_out),
    .remainder_out   (remainder_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .div_by_zero_out (div_by_zero_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero in signed mode.
  function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, lq, lr;
    z = (b == 32'd0);
    if (z) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end
  endfunction

  // Runs one operation; optionally drives a stray start pulse at pulse_cyc.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int pulse_cyc);
    logic [31:0] eq, er;
    logic        ez;
    int          cyc, done_at, busy_bad;
    model(sgn, a, b, eq, er, ez);
    @(negedge clk_in);
    signed_in = sgn; dividend_in = a; divisor_in = b; start_in = 1'b1;
    @(negedge clk_in);
    start_in    = 1'b0;
    dividend_in = $urandom;
    divisor_in  = $urandom;
    cyc = 1; done_at = 0; busy_bad = 0;
    while (cyc <= 40) begin
      start_in = (cyc == pulse_cyc);
      if (!busy_out) busy_bad++;
      if (done_out) begin
        done_at = cyc;
        break;
      end
      if (cyc == 1 || cyc == 10 || cyc == 33) begin
        check({tag, "_hold_q"}, quotient_out, last_q);
        check({tag, "_hold_r"}, remainder_out, last_r);
      end
      @(negedge clk_in);
      cyc++;
    end
    start_in = 1'b0;
    check({tag, "_latency"}, done_at, 34);
    check({tag, "_busy_low"}, busy_bad, 0);
    check({tag, "_q"}, quotient_out, eq);
    check({tag, "_r"}, remainder_out, er);
    check({tag, "_dbz"}, div_by_zero_out, ez);
    @(negedge clk_in);
    check({tag, "_done_pulse"}, done_out, 1'b0);
    check({tag, "_idle"}, busy_out, 1'b0);
    last_q = eq; last_r = er; last_z = ez;
  endtask

  initial begin
    logic [31:0] eq, er, a, b;
    logic        ez, sgn;
    int          cyc, done_at, dones;

    rst_in = 1'b1; start_in = 1'b0; signed_in = 1'b0;
    dividend_in = '0; divisor_in = '0;
    repeat (3) @(negedge clk_in);
    check("rst_q", quotient_out, 32'd0);
    check("rst_r", remainder_out, 32'd0);
    check("rst_busy", busy_out, 1'b0);
    check("rst_done", done_out, 1'b0);
    check("rst_dbz", div_by_zero_out, 1'b0);
    rst_in = 1'b0;

    // Directed corner cases.
    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
    run_op("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_op("divu_5_0",   1'b0, 32'd5, 32'd0, 0);
    run_op("divu_9_3",   1'b0, 32'd9, 32'd3, 0);
    run_op("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("div_m5_0",   1'b1, 32'hFFFF_FFFB, 32'd0, 0);

    // Stray start pulse mid-operation must be ignored.
    run_op("pulse10", 1'b0, 32'd1000, 32'd33, 10);

    // start_in held high: second op accepted in the first IDLE cycle.
    @(negedge clk_in);
    signed_in = 1'b0; dividend_in = 32'd77; divisor_in = 32'd5; start_in = 1'b1;
    @(negedge clk_in);
    signed_in = 1'b1; dividend_in = 32'hFFFF_FF9C; divisor_in = 32'd7;
    cyc = 1; done_at = 0;
    while (cyc <= 40 && !done_out) begin
      @(negedge clk_in);
      cyc++;
    end
    if (done_out) done_at = cyc;
    check("hold1_latency", done_at, 34);
    model(1'b0, 32'd77, 32'd5, eq, er, ez);
    check("hold1_q", quotient_out, eq);
    check("hold1_r", remainder_out, er);
    @(negedge clk_in);
    cyc++;
    check("hold_idle_gap", busy_out, 1'b0);
    @(negedge clk_in);
    cyc++;
    start_in = 1'b0;
    check("hold2_busy", busy_out, 1'b1);
    while (cyc <= 80 && !done_out) begin
      @(negedge clk_in);
      cyc++;
    end
    done_at = done_out ? cyc : 0;
    check("hold2_latency", done_at, 69);
    model(1'b1, 32'hFFFF_FF9C, 32'd7, eq, er, ez);
    check("hold2_q", quotient_out, eq);
    check("hold2_r", remainder_out, er);
    last_q = eq; last_r = er; last_z = ez;
    @(negedge clk_in);

    // Reset in the middle of an operation.
    @(negedge clk_in);
    signed_in = 1'b0; dividend_in = 32'd12345; divisor_in = 32'd67; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (14) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check("mid_rst_q", quotient_out, 32'd0);
    check("mid_rst_r", remainder_out, 32'd0);
    check("mid_rst_busy", busy_out, 1'b0);
    check("mid_rst_dbz", div_by_zero_out, 1'b0);
    last_q = '0; last_r = '0; last_z = 1'b0;
    dones = 0;
    repeat (40) begin
      if (done_out) dones++;
      @(negedge clk_in);
    end
    check("mid_rst_no_done", dones, 0);
    run_op("after_rst", 1'b0, 32'd12345, 32'd67, 0);

    // Randomized operands with biased corner values.
    for (int i = 0; i < 150; i++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        4: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op("rand", sgn, a, b, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
